// File: rtl/hilo_muldiv_pkg.sv
// rtl/hilo_muldiv_pkg.sv - shared widths, divide FSM states and sign helper for hilo_muldiv
package hilo_muldiv_pkg;

   localparam int HILO_WD   = 66;
   localparam int DIV_STEPS = 32;
   localparam int CNT_W     = $clog2(DIV_STEPS);

   typedef enum logic [1:0] {
      DIV_IDLE = 2'b00,
      DIV_BUSY = 2'b01,
      DIV_DONE = 2'b10
   } div_state_e;

   function automatic logic [31:0] apply_sign(input logic neg, input logic [31:0] v);
      return neg ? (~v + 32'd1) : v;
   endfunction

endpackage

// File: rtl/hilo_muldiv_div_core.sv
// rtl/hilo_muldiv_div_core.sv - iterative restoring divider, one quotient bit per cycle
module div_core
   import hilo_muldiv_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        start_i,
   input  logic        signed_op_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic        flush_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] quotient_o,
   output logic [31:0] remainder_o
);

   div_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [63:0]      acc_q, acc_d;      // {partial remainder, dividend bits shifting into quotient}
   logic [31:0]      dvs_q, dvs_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic [32:0]      trial;
   logic [31:0]      abs_a, abs_b;

   always_comb begin
      abs_a   = (signed_op_i && dividend_i[31]) ? apply_sign(1'b1, dividend_i) : dividend_i;
      abs_b   = (signed_op_i && divisor_i[31])  ? apply_sign(1'b1, divisor_i)  : divisor_i;
      trial   = acc_q[63:31] - {1'b0, dvs_q};
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      dvs_d   = dvs_q;
      qneg_d  = qneg_q;
      rneg_d  = rneg_q;
      busy_o  = 1'b0;
      done_o  = 1'b0;
      case (state_q)
         DIV_IDLE: begin
            if (start_i) begin
               busy_o = 1'b1;
               if (divisor_i == 32'd0) begin
                  acc_d   = {dividend_i, 32'hFFFF_FFFF};
                  qneg_d  = 1'b0;
                  rneg_d  = 1'b0;
                  state_d = DIV_DONE;
               end else begin
                  acc_d   = {32'd0, abs_a};
                  dvs_d   = abs_b;
                  qneg_d  = signed_op_i & (dividend_i[31] ^ divisor_i[31]);
                  rneg_d  = signed_op_i & dividend_i[31];
                  cnt_d   = '0;
                  state_d = DIV_BUSY;
               end
            end
         end
         DIV_BUSY: begin
            busy_o = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            // a non-negative trial difference means the divisor fits: keep it and set the quotient bit
            if (!trial[32]) acc_d = {trial[31:0], acc_q[30:0], 1'b1};
            else            acc_d = {acc_q[62:0], 1'b0};
            if (cnt_q == CNT_W'(DIV_STEPS - 1)) state_d = DIV_DONE;
         end
         DIV_DONE: begin
            done_o  = 1'b1;
            state_d = DIV_IDLE;
         end
         default: state_d = DIV_IDLE;
      endcase
      if (flush_i) begin
         state_d = DIV_IDLE;
         cnt_d   = '0;
         busy_o  = 1'b0;
         done_o  = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         acc_q   <= '0;
         dvs_q   <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         dvs_q   <= dvs_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
      end
   end

   assign quotient_o  = apply_sign(qneg_q, acc_q[31:0]);
   assign remainder_o = apply_sign(rneg_q, acc_q[63:32]);

endmodule

// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - EX-stage HI/LO producer: multiply, mthi/mtlo and stalling divide
module hilo_muldiv
   import hilo_muldiv_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               inst_div,
   input  logic               inst_divu,
   input  logic               inst_mult,
   input  logic               inst_multu,
   input  logic               inst_mthi,
   input  logic               inst_mtlo,
   input  logic [31:0]        src1,
   input  logic [31:0]        src2,
   input  logic               flush,
   output logic               stallreq_for_div,
   output logic [HILO_WD-1:0] ex_hilo
);

   logic               div_op, mul_op;
   logic               div_busy, div_done;
   logic [31:0]        div_quo, div_rem;
   logic signed [32:0] mul_a, mul_b;
   logic signed [63:0] prod;

   assign div_op = inst_div | inst_divu;
   assign mul_op = inst_mult | inst_multu;

   div_core u_div_core (
      .clk_i       (clk),
      .rst_i       (rst),
      .start_i     (div_op),
      .signed_op_i (inst_div),
      .dividend_i  (src1),
      .divisor_i   (src2),
      .flush_i     (flush),
      .busy_o      (div_busy),
      .done_o      (div_done),
      .quotient_o  (div_quo),
      .remainder_o (div_rem)
   );

   // one extra bit lets a single signed multiplier serve both mult and multu
   assign mul_a = {inst_mult & src1[31], src1};
   assign mul_b = {inst_mult & src2[31], src2};
   assign prod  = mul_a * mul_b;

   always_comb begin
      stallreq_for_div = div_busy & ~rst;
      ex_hilo          = '0;
      if (rst || flush)             ex_hilo = '0;
      else if (div_done)            ex_hilo = {2'b11, div_rem, div_quo};
      else if (div_op || div_busy)  ex_hilo = '0;
      else if (mul_op)              ex_hilo = {2'b11, prod};
      else if (inst_mthi)           ex_hilo = {2'b10, src1, 32'd0};
      else if (inst_mtlo)           ex_hilo = {2'b01, 32'd0, src1};
   end

endmodule
